// File: rtl/glitch_ctrl.sv
// Fault-injection glitch controller: arms with a delay/width pair, then fires a
// single registered glitch pulse a fixed number of cycles after a trigger edge.
module glitch_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic [15:0] delay_in,
  input  logic [7:0]  width_in,
  input  logic        trigger,
  input  logic        abort,
  output logic        glitch_out,
  output logic        armed,
  output logic        busy,
  output logic        done
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_GLITCH  = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   trig_d_r;
  logic                   trig_rise_s;
  logic [15:0]            dly_r;
  logic [7:0]             wid_r;
  logic [15:0]            dcnt_r;
  logic [7:0]             wcnt_r;
  logic [HW-1:0]          hcnt_r;

  // Trigger synchronizer chain and edge-detect register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r   <= '0;
      trig_d_r <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], trigger};
      trig_d_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign trig_rise_s = sync_r[SYNC_STAGES-1] & ~trig_d_r;

  // Shot sequencer; outputs are set on the same edge as the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      dly_r      <= 16'd0;
      wid_r      <= 8'd0;
      dcnt_r     <= 16'd0;
      wcnt_r     <= 8'd0;
      hcnt_r     <= '0;
      glitch_out <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      state_r    <= ST_IDLE;
      dcnt_r     <= 16'd0;
      wcnt_r     <= 8'd0;
      hcnt_r     <= '0;
      glitch_out <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          glitch_out <= 1'b0;
          // A trigger edge coinciding with arm is deliberately dropped.
          if (arm) begin
            dly_r   <= delay_in;
            wid_r   <= width_in;
            state_r <= ST_ARMED;
            armed   <= 1'b1;
            busy    <= 1'b1;
          end else begin
            armed <= 1'b0;
            busy  <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (trig_rise_s) begin
            armed <= 1'b0;
            if (dly_r == 16'd0) begin
              state_r    <= ST_GLITCH;
              wcnt_r     <= wid_r;
              glitch_out <= (wid_r != 8'd0);
            end else begin
              state_r <= ST_DELAY;
              dcnt_r  <= dly_r;
            end
          end else begin
            armed <= 1'b1;
          end
        end
        ST_DELAY: begin
          if (dcnt_r <= 16'd1) begin
            dcnt_r     <= 16'd0;
            state_r    <= ST_GLITCH;
            wcnt_r     <= wid_r;
            glitch_out <= (wid_r != 8'd0);
          end else begin
            dcnt_r <= dcnt_r - 16'd1;
          end
        end
        ST_GLITCH: begin
          // wcnt_r counts the high cycles remaining, including the current one.
          if (wcnt_r <= 8'd1) begin
            wcnt_r     <= 8'd0;
            glitch_out <= 1'b0;
            done       <= 1'b1;
            hcnt_r     <= HW'(HOLDOFF - 1);
            state_r    <= ST_HOLDOFF;
          end else begin
            wcnt_r <= wcnt_r - 8'd1;
          end
        end
        ST_HOLDOFF: begin
          if (hcnt_r == '0) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            hcnt_r <= hcnt_r - HW'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          glitch_out <= 1'b0;
          armed      <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_ctrl.sv
// Scoreboard bench for glitch_ctrl: stimulus queues expected glitches, done
// pulses and status snapshots; a negedge monitor pops and compares them.
module tb_glitch_ctrl;

  localparam int HOLD = 16;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic [15:0] delay_in = 16'd0;
  logic [7:0]  width_in = 8'd0;
  logic        trigger = 1'b0;
  logic        abort = 1'b0;
  logic        glitch_out, armed, busy, done;

  glitch_ctrl #(.SYNC_STAGES(SYNC), .HOLDOFF(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .delay_in(delay_in),
    .width_in(width_in), .trigger(trigger), .abort(abort),
    .glitch_out(glitch_out), .armed(armed), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic a; logic b; } stat_t;
  typedef struct { int start; int width; } glt_t;

  stat_t sq[$];
  glt_t  gq[$];
  int    dq[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT activity against the expectation queues.
  logic prev_g = 1'b0;
  int   g_start = 0;
  always @(negedge clk) begin
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      chk("status_cycle_reached", cyc, sq[0].cyc);
      chk("armed", int'(armed), int'(sq[0].a));
      chk("busy", int'(busy), int'(sq[0].b));
      void'(sq.pop_front());
    end
    if (glitch_out && !prev_g) g_start = cyc;
    if (!glitch_out && prev_g) begin
      if (gq.size() == 0) begin
        chk("unexpected_glitch_start", g_start, -1);
      end else begin
        chk("glitch_start", g_start, gq[0].start);
        chk("glitch_width", cyc - g_start, gq[0].width);
        void'(gq.pop_front());
      end
    end
    prev_g = glitch_out;
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", cyc, -1);
      else chk("done_cycle", cyc, dq.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic do_arm(input int d, input int w, input bit expect_arm);
    delay_in = 16'(d);
    width_in = 8'(w);
    arm = 1'b1;
    if (expect_arm) sq.push_back('{cyc + 1, 1'b1, 1'b1});
    step(1);
    arm = 1'b0;
  endtask

  // Raises trigger now; returns the cycle in which the synchronized edge lands.
  task automatic fire(output int t);
    trigger = 1'b1;
    t = cyc + SYNC;
  endtask

  task automatic expect_shot(input int t, input int d, input int w);
    int dn;
    dn = t + 1 + d + ((w == 0) ? 1 : w);
    if (w > 0) gq.push_back('{t + 1 + d, w});
    dq.push_back(dn);
    sq.push_back('{dn + HOLD - 1, 1'b0, 1'b1});
    sq.push_back('{dn + HOLD, 1'b0, 1'b0});
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, x;
    step(3);
    chk("reset_glitch", int'(glitch_out), 0);
    chk("reset_done", int'(done), 0);
    rst_n = 1'b1;
    sq.push_back('{cyc + 1, 1'b0, 1'b0});
    step(2);

    // Basic shot D=5 W=3.
    do_arm(5, 3, 1'b1);
    step(2);
    fire(t); expect_shot(t, 5, 3);
    step(3); trigger = 1'b0;
    step(40);

    // D=0 W=1, then D=10 W=0.
    do_arm(0, 1, 1'b1);
    step(2);
    fire(t); expect_shot(t, 0, 1);
    step(3); trigger = 1'b0;
    step(30);
    do_arm(10, 0, 1'b1);
    step(2);
    fire(t); expect_shot(t, 10, 0);
    step(3); trigger = 1'b0;
    step(40);

    // Abort mid-delay; later edges do nothing.
    do_arm(1000, 20, 1'b1);
    step(2);
    fire(t);
    step(3); trigger = 1'b0;
    step_to(t + 501);
    abort = 1'b1;
    sq.push_back('{cyc + 1, 1'b0, 1'b0});
    step(1); abort = 1'b0;
    step(3); trigger = 1'b1; step(4); trigger = 1'b0;
    sq.push_back('{cyc + 1100, 1'b0, 1'b0});
    step(1110);

    // Second edge during GLITCH, arm during HOLDOFF.
    do_arm(4, 8, 1'b1);
    step(2);
    fire(t); expect_shot(t, 4, 8);
    step(3); trigger = 1'b0;
    step_to(t + 4); trigger = 1'b1;
    step_to(t + 15);
    do_arm(2, 2, 1'b0);
    trigger = 1'b0;
    step_to(t + 40);
    trigger = 1'b1;
    sq.push_back('{cyc + 10, 1'b0, 1'b0});
    step(20); trigger = 1'b0;
    step(5);

    // Trigger edge lands in the arm cycle and stays high: must not fire.
    trigger = 1'b1;
    x = cyc;
    step_to(x + SYNC);
    do_arm(2, 2, 1'b1);
    sq.push_back('{x + 8, 1'b1, 1'b1});
    step(10);
    trigger = 1'b0;
    step(3);
    fire(t); expect_shot(t, 2, 2);
    step(3); trigger = 1'b0;
    step(30);

    // Abort beats arm in the same IDLE cycle.
    arm = 1'b1; abort = 1'b1; delay_in = 16'd1; width_in = 8'd1;
    sq.push_back('{cyc + 1, 1'b0, 1'b0});
    step(1); arm = 1'b0; abort = 1'b0;
    sq.push_back('{cyc + 3, 1'b0, 1'b0});
    step(5);

    // Extremes D=65535 W=255.
    do_arm(65535, 255, 1'b1);
    step(2);
    fire(t); expect_shot(t, 65535, 255);
    step(3); trigger = 1'b0;
    step(65536 + 255 + HOLD + 10);

    // Reset mid-glitch drops the output asynchronously.
    do_arm(3, 50, 1'b1);
    step(2);
    fire(t);
    step(3); trigger = 1'b0;
    x = t + 4 + 20;
    gq.push_back('{t + 4, x - (t + 4)});
    step_to(x);
    chk("glitch_before_reset", int'(glitch_out), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_glitch", int'(glitch_out), 0);
    chk("async_reset_busy", int'(busy), 0);
    step(2);
    rst_n = 1'b1;
    sq.push_back('{cyc + 1, 1'b0, 1'b0});
    step(3); trigger = 1'b1; step(20); trigger = 1'b0;
    sq.push_back('{cyc + 1, 1'b0, 1'b0});
    step(5);

    chk("glitch_queue_empty", gq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    chk("status_queue_empty", sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
